// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: the four 3-bit lamp buses, {red,yellow,green}.
// The controller drives them as master; the monitor only observes as slave.
interface traffic_light_monitor_if;
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;

    modport master (output m1, m2, mt, s);
    modport slave  (input  m1, m2, mt, s);
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive safety checker on the traffic-light lamp buses.
// Define TLMON_CONFLICT_EN to build in the right-of-way conflict check.
module traffic_light_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_YELLOW = 6,
    parameter int MAX_GREEN  = 40,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    traffic_light_monitor_if.slave  lamps,
    input  logic                    clr_err,
    output logic [3:0]              seq_err,
    output logic [3:0]              tim_err,
    output logic                    conflict,
    output logic                    alarm,
    output logic [2:0]              first_err,
    output logic [7:0]              s_grants
);

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_Y   = CNT_W'(MAX_YELLOW);
    localparam logic [CNT_W-1:0] MAX_G   = CNT_W'(MAX_GREEN);

    // road index: 0 m1, 1 m2, 2 mt, 3 s
    logic [2:0]       lamp  [4];
    state_t           st_q  [4];
    state_t           st_d  [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             armed_q;

    logic [3:0] enc_e;
    logic [3:0] seq_e;
    logic [3:0] ys_e;
    logic [3:0] yl_e;
    logic [3:0] gl_e;
    logic       grant;
    logic       conf_e;
    logic       conf_n;
    logic [2:0] code;
    logic [3:0] seq_n;
    logic [3:0] tim_n;
    logic [2:0] fe_base;

    assign lamp[0] = lamps.m1;
    assign lamp[1] = lamps.m2;
    assign lamp[2] = lamps.mt;
    assign lamp[3] = lamps.s;

    // Per-road tracker: decode lamps, pick next state/count, flag faults
    always_comb begin : trk
        logic   vok;
        state_t vst;
        logic   held;
        vok   = 1'b1;
        vst   = RED;
        held  = 1'b1;
        grant = 1'b0;
        enc_e = '0;
        seq_e = '0;
        ys_e  = '0;
        yl_e  = '0;
        gl_e  = '0;
        for (int r = 0; r < 4; r++) begin
            vok      = 1'b1;
            vst      = RED;
            held     = 1'b1;
            st_d[r]  = st_q[r];
            cnt_d[r] = (cnt_q[r] == CNT_SAT) ? CNT_SAT : cnt_q[r] + ONE;
            case (lamp[r])
                3'b100:  vst = RED;
                3'b001:  vst = GREEN;
                3'b010:  vst = YELLOW;
                default: vok = 1'b0;
            endcase
            if (!vok) begin
                // bad encoding: hold state, keep counting
                enc_e[r] = 1'b1;
            end else if (!armed_q) begin
                // first sample: adopt whatever is shown
                st_d[r]  = vst;
                cnt_d[r] = ONE;
                held     = 1'b0;
            end else if (vst != st_q[r]) begin
                // move regardless so checking resyncs
                st_d[r]  = vst;
                cnt_d[r] = ONE;
                held     = 1'b0;
                seq_e[r] = !((st_q[r] == RED    && vst == GREEN)  ||
                             (st_q[r] == GREEN  && vst == YELLOW) ||
                             (st_q[r] == YELLOW && vst == RED));
                ys_e[r]  = (st_q[r] == YELLOW) && (cnt_q[r] < MIN_Y);
                if (r == 3 && st_q[r] == RED && vst == GREEN)
                    grant = 1'b1;
            end
            // exact match on the step to MAX+1 fires once per interval
            yl_e[r] = held && (st_q[r] == YELLOW) && (cnt_q[r] == MAX_Y);
            gl_e[r] = held && (st_q[r] == GREEN)  && (cnt_q[r] == MAX_G);
        end
    end

`ifdef TLMON_CONFLICT_EN
    logic [3:0] act;

    // Right-of-way: any non-red road is active; undecodable counts as active
    always_comb begin
        for (int r = 0; r < 4; r++)
            act[r] = (lamp[r] != 3'b100);
        conf_e = (act[3] && (act[0] || act[1] || act[2])) ||
                 (act[2] && act[1]);
        conf_n = (clr_err ? 1'b0 : conflict) | conf_e;
    end

    // Sticky conflict flag
    always_ff @(posedge clk) begin
        if (rst)
            conflict <= 1'b0;
        else
            conflict <= conf_n;
    end
`else
    assign conf_e   = 1'b0;
    assign conf_n   = 1'b0;
    assign conflict = 1'b0;
`endif

    // Lowest error code present this cycle
    always_comb begin
        code = 3'd0;
        if (|enc_e)
            code = 3'd1;
        else if (|seq_e)
            code = 3'd2;
        else if (|ys_e)
            code = 3'd3;
        else if (|yl_e)
            code = 3'd4;
        else if (|gl_e)
            code = 3'd5;
        else if (conf_e)
            code = 3'd6;
    end

    // Next sticky values: a clear yields to a new error in the same cycle
    always_comb begin
        seq_n   = (clr_err ? 4'd0 : seq_err) | enc_e | seq_e;
        tim_n   = (clr_err ? 4'd0 : tim_err) | ys_e | yl_e | gl_e;
        fe_base = clr_err ? 3'd0 : first_err;
    end

    // Tracker state and duration counters
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                st_q[r]  <= RED;
                cnt_q[r] <= '0;
            end
        end else begin
            armed_q <= 1'b1;
            for (int r = 0; r < 4; r++) begin
                st_q[r]  <= st_d[r];
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Sticky flags, first-error capture, alarm and side-road grant count
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_err   <= '0;
            tim_err   <= '0;
            alarm     <= 1'b0;
            first_err <= '0;
            s_grants  <= '0;
        end else begin
            seq_err   <= seq_n;
            tim_err   <= tim_n;
            alarm     <= (|seq_n) | (|tim_n) | conf_n;
            first_err <= (fe_base == 3'd0) ? code : fe_base;
            s_grants  <= s_grants + {7'd0, grant};
        end
    end

endmodule
